// File: rtl/exers_scalu_rs_if.sv
// rtl/exers_scalu_rs_if.sv - dispatch, writeback, issue and control signals of the scalu reservation station
interface exers_scalu_rs_if;
  logic        dispatch_valid;
  logic [4:0]  dispatch_op;
  logic [6:0]  dispatch_robid;
  logic [5:0]  dispatch_rd;
  logic        dispatch_op1_rdy;
  logic [31:0] dispatch_op1;
  logic        dispatch_op2_rdy;
  logic [31:0] dispatch_op2;
  logic        exers_stall;
  logic        wb_valid;
  logic [6:0]  wb_robid;
  logic [31:0] wb_result;
  logic        exers_scalu_issue;
  logic [4:0]  exers_scalu_op;
  logic [6:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1;
  logic [31:0] exers_op2;
  logic        scalu_stall;
  logic        rob_flush;

  modport master (
    output dispatch_valid, dispatch_op, dispatch_robid, dispatch_rd,
           dispatch_op1_rdy, dispatch_op1, dispatch_op2_rdy, dispatch_op2,
           wb_valid, wb_robid, wb_result, scalu_stall, rob_flush,
    input  exers_stall, exers_scalu_issue, exers_scalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );

  modport slave (
    input  dispatch_valid, dispatch_op, dispatch_robid, dispatch_rd,
           dispatch_op1_rdy, dispatch_op1, dispatch_op2_rdy, dispatch_op2,
           wb_valid, wb_robid, wb_result, scalu_stall, rob_flush,
    output exers_stall, exers_scalu_issue, exers_scalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );
endinterface

// File: rtl/exers_scalu_rs.sv
// rtl/exers_scalu_rs.sv - collapsing-queue reservation station issuing oldest ready op to scalu
module exers_scalu_rs #(
  parameter int DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  exers_scalu_rs_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic        r1;
    logic [31:0] v1;
    logic        r2;
    logic [31:0] v2;
  } entry_t;

  entry_t ent  [DEPTH];
  entry_t woke [DEPTH+1];
  entry_t nxt  [DEPTH];
  entry_t din;

  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [CW-1:0] ins;
  logic [IW-1:0] sel;
  logic          found;
  logic          issue;
  logic          accept;

  assign bus.exers_stall = (count == CW'(DEPTH));
  assign accept = bus.dispatch_valid & ~bus.exers_stall & ~bus.rob_flush;
  assign issue  = found & ~bus.scalu_stall & ~bus.rob_flush;

  // Descending scan so the last hit is the oldest ready slot.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent[i].valid && ent[i].r1 && ent[i].r2) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign bus.exers_scalu_issue = issue;
  assign bus.exers_scalu_op    = ent[sel].op;
  assign bus.exers_robid       = ent[sel].robid;
  assign bus.exers_rd          = ent[sel].rd;
  assign bus.exers_op1         = ent[sel].v1;
  assign bus.exers_op2         = ent[sel].v2;

  // Wakeup is applied before the shift so moved entries keep same-cycle captures.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent[i];
      if (bus.wb_valid && ent[i].valid) begin
        if (!ent[i].r1 && ent[i].v1[6:0] == bus.wb_robid) begin
          woke[i].r1 = 1'b1;
          woke[i].v1 = bus.wb_result;
        end
        if (!ent[i].r2 && ent[i].v2[6:0] == bus.wb_robid) begin
          woke[i].r2 = 1'b1;
          woke[i].v2 = bus.wb_result;
        end
      end
    end
    woke[DEPTH] = '0;
  end

  always_comb begin
    din       = '0;
    din.valid = 1'b1;
    din.op    = bus.dispatch_op;
    din.robid = bus.dispatch_robid;
    din.rd    = bus.dispatch_rd;
    din.r1    = bus.dispatch_op1_rdy;
    din.v1    = bus.dispatch_op1;
    din.r2    = bus.dispatch_op2_rdy;
    din.v2    = bus.dispatch_op2;
    if (!bus.dispatch_op1_rdy && bus.wb_valid && bus.dispatch_op1[6:0] == bus.wb_robid) begin
      din.r1 = 1'b1;
      din.v1 = bus.wb_result;
    end
    if (!bus.dispatch_op2_rdy && bus.wb_valid && bus.dispatch_op2[6:0] == bus.wb_robid) begin
      din.r2 = 1'b1;
      din.v2 = bus.wb_result;
    end
  end

  always_comb begin
    ins     = count - CW'(issue);
    count_n = count + CW'(accept) - CW'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && i >= int'(sel)) nxt[i] = woke[i+1];
      else                         nxt[i] = woke[i];
      if (accept && ins == CW'(i)) nxt[i] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.rob_flush) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      count <= count_n;
      for (int i = 0; i < DEPTH; i++) ent[i] <= nxt[i];
    end
  end
endmodule

// File: tb/tb_exers_scalu_rs.sv
// tb/tb_exers_scalu_rs.sv - scoreboard bench for the scalu reservation station
module tb_exers_scalu_rs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exers_scalu_rs_if bus ();

  exers_scalu_rs #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  robid;
    logic [4:0]  op;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  exp_t exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic [6:0] robid, input logic [4:0] op, input logic [5:0] rd,
                      input logic [31:0] op1, input logic [31:0] op2);
    exp_t e;
    e.robid = robid; e.op = op; e.rd = rd; e.op1 = op1; e.op2 = op2;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.exers_scalu_issue === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue robid=%0d want no issue at %0t", bus.exers_robid, $time);
      end else begin
        e = exp_q.pop_front();
        chk("issue_robid", 32'(bus.exers_robid), 32'(e.robid));
        chk("issue_op", 32'(bus.exers_scalu_op), 32'(e.op));
        chk("issue_rd", 32'(bus.exers_rd), 32'(e.rd));
        chk("issue_op1", bus.exers_op1, e.op1);
        chk("issue_op2", bus.exers_op2, e.op2);
      end
    end
  end

  task automatic disp(input logic [4:0] op, input logic [6:0] robid, input logic [5:0] rd,
                      input logic r1, input logic [31:0] o1, input logic r2, input logic [31:0] o2);
    bus.dispatch_valid   = 1'b1;
    bus.dispatch_op      = op;
    bus.dispatch_robid   = robid;
    bus.dispatch_rd      = rd;
    bus.dispatch_op1_rdy = r1;
    bus.dispatch_op1     = o1;
    bus.dispatch_op2_rdy = r2;
    bus.dispatch_op2     = o2;
  endtask

  task automatic wb(input logic [6:0] tag, input logic [31:0] res);
    bus.wb_valid  = 1'b1;
    bus.wb_robid  = tag;
    bus.wb_result = res;
  endtask

  // One cycle: sample mid-cycle, then advance past the edge and drop one-shot inputs.
  task automatic cyc(input string name, input logic want_issue, input logic want_stall);
    @(negedge clk);
    chk({name, "_issue"}, 32'(bus.exers_scalu_issue), 32'(want_issue));
    chk({name, "_stall"}, 32'(bus.exers_stall), 32'(want_stall));
    @(posedge clk);
    #1;
    bus.dispatch_valid = 1'b0;
    bus.wb_valid       = 1'b0;
    bus.rob_flush      = 1'b0;
  endtask

  initial begin
    bus.dispatch_valid = 1'b0; bus.dispatch_op = '0; bus.dispatch_robid = '0;
    bus.dispatch_rd = '0; bus.dispatch_op1_rdy = 1'b0; bus.dispatch_op1 = '0;
    bus.dispatch_op2_rdy = 1'b0; bus.dispatch_op2 = '0;
    bus.wb_valid = 1'b0; bus.wb_robid = '0; bus.wb_result = '0;
    bus.scalu_stall = 1'b0; bus.rob_flush = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 1'b0, 1'b0);
    rst = 1'b0;

    disp(5'd0, 7'd3, 6'd1, 1'b1, 32'd5, 1'b1, 32'd7);
    push(7'd3, 5'd0, 6'd1, 32'd5, 32'd7);
    cyc("t1_disp", 1'b0, 1'b0);
    cyc("t1_issue", 1'b1, 1'b0);
    cyc("t1_empty", 1'b0, 1'b0);

    disp(5'd1, 7'd4, 6'd2, 1'b0, 32'd9, 1'b1, 32'd2);
    cyc("t2_disp", 1'b0, 1'b0);
    cyc("t2_wait", 1'b0, 1'b0);
    wb(7'd9, 32'h1234);
    push(7'd4, 5'd1, 6'd2, 32'h1234, 32'd2);
    cyc("t2_wb", 1'b0, 1'b0);
    cyc("t2_issue", 1'b1, 1'b0);
    cyc("t2_empty", 1'b0, 1'b0);

    disp(5'd2, 7'd5, 6'd3, 1'b1, 32'd3, 1'b0, 32'd9);
    wb(7'd9, 32'hAA);
    push(7'd5, 5'd2, 6'd3, 32'd3, 32'hAA);
    cyc("t3_bypass", 1'b0, 1'b0);
    cyc("t3_issue", 1'b1, 1'b0);
    cyc("t3_empty", 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      disp(5'd3, 7'(20 + i), 6'(i), 1'b0, 32'(40 + i), 1'b1, 32'(i));
      cyc("t4_fill", 1'b0, 1'b0);
    end
    disp(5'd4, 7'd30, 6'd9, 1'b1, 32'd1, 1'b1, 32'd1);
    cyc("t4_drop", 1'b0, 1'b1);
    wb(7'd45, 32'h55);
    push(7'd25, 5'd3, 6'd5, 32'h55, 32'd5);
    cyc("t4_wake5", 1'b0, 1'b1);
    cyc("t4_issue5", 1'b1, 1'b1);
    bus.scalu_stall = 1'b1;
    wb(7'd47, 32'h77);
    cyc("t4_unfull", 1'b0, 1'b0);
    wb(7'd46, 32'h66);
    cyc("t4_held", 1'b0, 1'b0);
    bus.scalu_stall = 1'b0;
    push(7'd26, 5'd3, 6'd6, 32'h66, 32'd6);
    push(7'd27, 5'd3, 6'd7, 32'h77, 32'd7);
    cyc("t4_slot5", 1'b1, 1'b0);
    cyc("t4_slot6", 1'b1, 1'b0);
    bus.rob_flush = 1'b1;
    cyc("t4_flush", 1'b0, 1'b0);
    cyc("t4_clear", 1'b0, 1'b0);

    bus.scalu_stall = 1'b1;
    disp(5'd5, 7'd50, 6'd10, 1'b1, 32'h50, 1'b1, 32'd1);
    cyc("t5_d0", 1'b0, 1'b0);
    disp(5'd5, 7'd51, 6'd11, 1'b0, 32'd60, 1'b1, 32'd2);
    cyc("t5_d1", 1'b0, 1'b0);
    disp(5'd5, 7'd52, 6'd12, 1'b1, 32'h52, 1'b1, 32'd3);
    cyc("t5_d2", 1'b0, 1'b0);
    disp(5'd5, 7'd53, 6'd13, 1'b0, 32'd61, 1'b1, 32'd4);
    cyc("t5_stall", 1'b0, 1'b0);
    cyc("t5_stall", 1'b0, 1'b0);
    cyc("t5_stall", 1'b0, 1'b0);
    bus.scalu_stall = 1'b0;
    push(7'd50, 5'd5, 6'd10, 32'h50, 32'd1);
    push(7'd52, 5'd5, 6'd12, 32'h52, 32'd3);
    cyc("t5_first", 1'b1, 1'b0);
    cyc("t5_second", 1'b1, 1'b0);
    wb(7'd60, 32'h60);
    push(7'd51, 5'd5, 6'd11, 32'h60, 32'd2);
    cyc("t5_wb", 1'b0, 1'b0);
    cyc("t5_third", 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      disp(5'd6, 7'(54 + i), 6'(20 + i), 1'b0, 32'(70 + i), 1'b1, 32'd0);
      cyc("t6_fill", 1'b0, 1'b0);
    end
    bus.scalu_stall = 1'b1;
    disp(5'd6, 7'd57, 6'd23, 1'b1, 32'h57, 1'b1, 32'h58);
    cyc("t6_fill_rdy", 1'b0, 1'b0);
    bus.scalu_stall = 1'b0;
    bus.rob_flush = 1'b1;
    disp(5'd7, 7'd58, 6'd24, 1'b1, 32'd1, 1'b1, 32'd1);
    cyc("t6_flush", 1'b0, 1'b0);
    wb(7'd61, 32'h61);
    cyc("t6_after", 1'b0, 1'b0);
    cyc("t6_after", 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      disp(5'd8, 7'(80 + i), 6'(i), 1'b0, 32'(100 + i), 1'b0, 32'(100 + i));
      cyc("t6_refill", 1'b0, 1'b0);
    end
    cyc("t6_full", 1'b0, 1'b1);

    rst = 1'b1;
    cyc("rst_mid", 1'b0, 1'b1);
    rst = 1'b0;
    cyc("rst_clear", 1'b0, 1'b0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
